dp_mod_ctrl: RTL
================

# dp_mod_ctrl

Sequencing and configuration controller for the `dp_mod` AM/FM modulator datapath. It holds shadow and active copies of the modulator configuration: carrier frequency word, AM/FM modulation indices and mode. It paces input samples into `dp_mod` at a programmable sample rate and tracks samples in flight. On reconfiguration it drains the pipeline and pulses the datapath reset, so a new configuration never mixes with samples started under the old one. It sits between the sample source and the register bus on one side and `dp_mod` on the other.

## Interface

Parameters:
- `W`, 16: sample width.
- `M`, 24: carrier frequency word width.
- `DIV_W`, 16: sample-period divider width.
- `FL_W`, 8: in-flight counter width.

Ports:
- `clk`  in  1: clock.
- `ic_rst_n`  in  1: reset, asynchronous, active-low.
- `ic_cfg_we`  in  1: shadow register write strobe.
- `ic_cfg_addr`  in  2: shadow register select. 0 = frec_por, 1 = im_am, 2 = im_fm, 3 = ctrl (bit0 fm_am, bit1 enable).
- `id_cfg_data`  in  M: write data. Narrower registers take the LSBs.
- `ic_cfg_commit`  in  1: request shadow→active transfer.
- `id_div`  in  DIV_W: sample period minus 1, in clocks.
- `id_data`  in  W: source sample.
- `ic_src_val`  in  1: source sample valid.
- `oc_src_rdy`  out  1: sample accepted this cycle (combinational).
- `od_dp_data`  out  W: to `dp_mod` `id_data`.
- `od_frec_por`  out  M: to `dp_mod` `id_frec_por`.
- `od_im_am`  out  16: to `dp_mod` `id_im_am`.
- `od_im_fm`  out  16: to `dp_mod` `id_im_fm`.
- `oc_fm_am`  out  1: to `dp_mod` `ic_fm_am`.
- `oc_dp_rst`  out  1: to `dp_mod` `ic_rst`, active-high.
- `oc_dp_val`  out  1: to `dp_mod` `ic_val_data`.
- `ic_dp_val`  in  1: from `dp_mod` `oc_val_data`.
- `oc_state`  out  2: current FSM state encoding.
- `od_out_cnt`  out  16: count of `dp_mod` output samples.
- `oc_underrun`  out  1: sticky; a sample slot passed with no source data.

## Operation

- **Reset values:**
  - State IDLE; `oc_state`=0.
  - `oc_dp_rst`=1.
  - Shadow registers, active registers, `od_*` outputs, `oc_dp_val`, `oc_src_rdy`, `oc_underrun` all 0.
  - In-flight counter, divider counter and `od_out_cnt` 0.
  - Pending-commit flag 0.
- **Shadow registers:**
  - Written on `ic_cfg_we` in any state.
  - A shadow→active copy uses shadow contents as of the start of the copy cycle. A write in that same cycle is not included in the copy.
- **IDLE (0):**
  - `oc_dp_rst`=1.
  - On `ic_cfg_commit`: copy shadow→active. If shadow enable=1, go to RUN; otherwise stay in IDLE.
- **RUN (1):**
  - `oc_dp_rst`=0. The divider counter enters at 0.
  - A cycle with counter==0 is a slot. The counter then reloads `id_div`; otherwise it decrements.
  - Slot with `ic_src_val`=1:
    - `oc_src_rdy`=1.
    - `id_data` is registered to `od_dp_data`.
    - `oc_dp_val`=1 on the next cycle.
  - Slot with `ic_src_val`=0: no sample is issued and `oc_underrun` is set.
  - `ic_cfg_commit` sets the pending flag. Repeated commits while pending have no further effect.
  - At the first slot with the pending flag set: no sample is accepted and the FSM goes to DRAIN.
- **DRAIN (2):**
  - No samples issued; `oc_src_rdy`=0.
  - Waits until the in-flight count is 0, then goes to FLUSH.
- **FLUSH (3):**
  - Lasts exactly 2 cycles with `oc_dp_rst`=1.
  - The first cycle copies shadow→active and clears the pending flag.
  - Then goes to RUN if the active enable=1, else to IDLE.
- **In-flight counter:**
  - +1 on `oc_dp_val`, −1 on `ic_dp_val`; both in the same cycle leaves it unchanged.
  - Saturates at 0 and at 2^FL_W−1.
- **`od_out_cnt`:** increments on each `ic_dp_val` in any state and wraps 0xFFFF→0.
- **`id_div` changes:** take effect at the next reload.
- **`ic_rst_n` asserted mid-operation:** all state returns to the reset values immediately. Samples in flight are discarded.

## Timing

- Enter RUN at cycle t: first slot at t, `oc_dp_val` at t+1, subsequent slots every `id_div`+1 cycles. `id_div`=0 gives a slot every cycle.
- `oc_src_rdy` is combinational within the slot cycle. The source holds `id_data`/`ic_src_val` until it sees `oc_src_rdy`.
- Commit in IDLE at cycle t (enable=1): active registers updated and `oc_dp_rst` low from t+1.
- Reconfiguration latency: pending slot, then DRAIN (≥1 cycle), then 2 FLUSH cycles. Active registers change in the first FLUSH cycle, while `oc_dp_rst`=1.

## Configuration

- `DP_MOD_CTRL_UNDERRUN_EN`, defined: `oc_underrun` is a sticky flag set on an empty slot and cleared on every shadow→active copy.
- Not defined: `oc_underrun` is tied to 0 and no underrun logic is built. Empty slots are still skipped silently.

## Test plan

- **Reset:** assert `ic_rst_n`=0 mid-RUN → all outputs at reset values in the same cycle, `oc_dp_rst`=1, `oc_state`=0.
- **Start-up:** write frec_por=0x001000, im_am=0x4000, ctrl=0b10, then commit → next cycle `od_frec_por`=0x001000, `oc_fm_am`=0, `oc_state`=1, `oc_dp_rst`=0.
- **Pacing:** `id_div`=3 with `ic_src_val` held at 1 → `oc_dp_val` pulses every 4 cycles; 100 samples give `oc_src_rdy` count = 100.
- **Reconfiguration:** with 5 samples in flight and commit of ctrl=0b11, delay `ic_dp_val` 8 cycles → `oc_state` 2 until in-flight=0, then 2 cycles of `oc_dp_rst`=1, then `oc_fm_am`=1 and RUN resumes.
- **Underrun:** `id_div`=1, drop `ic_src_val` for one slot → no `oc_dp_val` for that slot, `oc_underrun`=1 (macro defined) or 0 (undefined); the next commit clears it.
- **Simultaneous/wrap:** `oc_dp_val` and `ic_dp_val` in the same cycle → in-flight unchanged; 65536 outputs → `od_out_cnt`=0.

Source files
------------

// File: rtl/dp_mod_ctrl.sv
// ============================================================================
// dp_mod_ctrl
// ----------------------------------------------------------------------------
// Sequencing and configuration controller for the dp_mod AM/FM modulator.
//
// Purpose:
//   - Holds shadow and active copies of the modulator configuration
//     (carrier frequency word, AM/FM modulation indices, mode/enable).
//   - Paces source samples into dp_mod at a programmable sample period.
//   - Tracks samples in flight inside dp_mod.
//   - On reconfiguration: drains the pipeline, then pulses the datapath reset
//     for two cycles while swapping in the new configuration. A new
//     configuration therefore never mixes with samples started under the
//     old one.
//
// Optional feature (compile-time macro):
//   DP_MOD_CTRL_UNDERRUN_EN
//     defined     : oc_underrun is a sticky flag. It is set on an empty sample
//                   slot and cleared on every shadow->active copy.
//     not defined : oc_underrun is tied to 0. Empty slots are still skipped.
//
// Ports:
//   clk            clock
//   ic_rst_n       asynchronous active-low reset
//   ic_cfg_we      shadow register write strobe
//   ic_cfg_addr    shadow select: 0 frec_por, 1 im_am, 2 im_fm,
//                  3 ctrl (bit0 fm_am, bit1 enable)
//   id_cfg_data    write data; narrower registers take the LSBs
//   ic_cfg_commit  request shadow->active transfer
//   id_div         sample period minus 1, in clocks
//   id_data        source sample
//   ic_src_val     source sample valid
//   oc_src_rdy     sample accepted this cycle (combinational)
//   od_dp_data     sample to dp_mod
//   od_frec_por    active carrier frequency word
//   od_im_am       active AM index
//   od_im_fm       active FM index
//   oc_fm_am       active mode select
//   oc_dp_rst      dp_mod reset, active-high
//   oc_dp_val      sample valid to dp_mod
//   ic_dp_val      output valid from dp_mod
//   oc_state       FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 FLUSH)
//   od_out_cnt     count of dp_mod output samples (wraps)
//   oc_underrun    sticky empty-slot flag (see macro above)
//
// Note: M must be at least 16, because the 16-bit index registers are loaded
// from the LSBs of id_cfg_data.
// ============================================================================
module dp_mod_ctrl #(
    parameter int W     = 16,
    parameter int M     = 24,
    parameter int DIV_W = 16,
    parameter int FL_W  = 8
) (
    input  logic             clk,
    input  logic             ic_rst_n,
    input  logic             ic_cfg_we,
    input  logic [1:0]       ic_cfg_addr,
    input  logic [M-1:0]     id_cfg_data,
    input  logic             ic_cfg_commit,
    input  logic [DIV_W-1:0] id_div,
    input  logic [W-1:0]     id_data,
    input  logic             ic_src_val,
    output logic             oc_src_rdy,
    output logic [W-1:0]     od_dp_data,
    output logic [M-1:0]     od_frec_por,
    output logic [15:0]      od_im_am,
    output logic [15:0]      od_im_fm,
    output logic             oc_fm_am,
    output logic             oc_dp_rst,
    output logic             oc_dp_val,
    input  logic             ic_dp_val,
    output logic [1:0]       oc_state,
    output logic [15:0]      od_out_cnt,
    output logic             oc_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
    localparam logic [FL_W-1:0]  FL_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_flush_2nd;   // second of the two FLUSH cycles
    logic             r_pending;     // commit seen in RUN, not yet applied
    logic             r_dp_rst;
    logic [DIV_W-1:0] r_div_cnt;
    logic [FL_W-1:0]  r_inflight;
    logic [15:0]      r_out_cnt;
    logic             r_dp_val;
    logic [W-1:0]     r_dp_data;

    logic [M-1:0]     r_sh_frec;
    logic [15:0]      r_sh_im_am;
    logic [15:0]      r_sh_im_fm;
    logic [1:0]       r_sh_ctrl;

    logic [M-1:0]     r_act_frec;
    logic [15:0]      r_act_im_am;
    logic [15:0]      r_act_im_fm;
    logic [1:0]       r_act_ctrl;

    // ------------------------------------------------------------------
    // Slot decode
    // ------------------------------------------------------------------
    logic w_slot;
    logic w_accept;
    logic w_copy;

    // A slot is any RUN cycle where the period counter has reached zero.
    assign w_slot   = (r_state == ST_RUN) && (r_div_cnt == '0);

    // A pending reconfiguration consumes the slot: nothing is accepted so
    // the old configuration gets no new samples.
    assign w_accept = w_slot && !r_pending && ic_src_val;

    // Shadow->active copy happens on a commit in IDLE, or in the first
    // FLUSH cycle (while dp_mod is held in reset).
    assign w_copy   = ((r_state == ST_IDLE) && ic_cfg_commit) ||
                      ((r_state == ST_FLUSH) && !r_flush_2nd);

    // ------------------------------------------------------------------
    // Shadow registers: writable in any state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_sh_frec  <= '0;
            r_sh_im_am <= '0;
            r_sh_im_fm <= '0;
            r_sh_ctrl  <= '0;
        end else if (ic_cfg_we) begin
            case (ic_cfg_addr)
                2'd0:    r_sh_frec  <= id_cfg_data;
                2'd1:    r_sh_im_am <= id_cfg_data[15:0];
                2'd2:    r_sh_im_fm <= id_cfg_data[15:0];
                default: r_sh_ctrl  <= id_cfg_data[1:0];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Active registers. The copy samples the shadow registers as they were
    // at the start of the cycle, so a write in the copy cycle is not
    // included.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_act_frec  <= '0;
            r_act_im_am <= '0;
            r_act_im_fm <= '0;
            r_act_ctrl  <= '0;
        end else if (w_copy) begin
            r_act_frec  <= r_sh_frec;
            r_act_im_am <= r_sh_im_am;
            r_act_im_fm <= r_sh_im_fm;
            r_act_ctrl  <= r_sh_ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Sample-period counter. It is held at 0 outside RUN, so the first RUN
    // cycle is always a slot. id_div is sampled only at reload.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_div_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_div_cnt <= '0;
        end else if (w_slot) begin
            r_div_cnt <= id_div;
        end else begin
            r_div_cnt <= r_div_cnt - DIV_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_2nd <= 1'b0;
            r_pending   <= 1'b0;
            r_dp_rst    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Enable is taken from the shadow copy being committed.
                    if (ic_cfg_commit && r_sh_ctrl[1]) begin
                        r_state  <= ST_RUN;
                        r_dp_rst <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ic_cfg_commit) begin
                        r_pending <= 1'b1;
                    end
                    // The flag is sampled at the slot with its old value; a
                    // commit in the slot cycle waits for the next slot.
                    if (w_slot && r_pending) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state     <= ST_FLUSH;
                        r_flush_2nd <= 1'b0;
                        r_dp_rst    <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!r_flush_2nd) begin
                        r_flush_2nd <= 1'b1;
                        r_pending   <= 1'b0;
                    end else begin
                        r_flush_2nd <= 1'b0;
                        // Active copy was loaded in the first FLUSH cycle.
                        if (r_act_ctrl[1]) begin
                            r_state  <= ST_RUN;
                            r_dp_rst <= 1'b0;
                        end else begin
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_dp_rst <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample issue into dp_mod
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_dp_val  <= 1'b0;
            r_dp_data <= '0;
        end else begin
            r_dp_val <= w_accept;
            if (w_accept) begin
                r_dp_data <= id_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // In-flight counter: issue and return in one cycle cancel out.
    // Saturates at both ends.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_inflight <= '0;
        end else if (r_dp_val && !ic_dp_val) begin
            if (r_inflight != FL_MAX) begin
                r_inflight <= r_inflight + FL_ONE;
            end
        end else if (!r_dp_val && ic_dp_val) begin
            if (r_inflight != '0) begin
                r_inflight <= r_inflight - FL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output sample counter: counts in every state and wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_out_cnt <= '0;
        end else if (ic_dp_val) begin
            r_out_cnt <= r_out_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Underrun flag
    // ------------------------------------------------------------------
`ifdef DP_MOD_CTRL_UNDERRUN_EN
    logic r_underrun;
    logic w_empty;

    // A pending-reconfiguration slot is intentionally empty and does not
    // count as an underrun.
    assign w_empty = w_slot && !r_pending && !ic_src_val;

    always_ff @(posedge clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_copy) begin
            r_underrun <= 1'b0;
        end else if (w_empty) begin
            r_underrun <= 1'b1;
        end
    end

    assign oc_underrun = r_underrun;
`else
    assign oc_underrun = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oc_src_rdy  = w_accept;
    assign od_dp_data  = r_dp_data;
    assign oc_dp_val   = r_dp_val;
    assign od_frec_por = r_act_frec;
    assign od_im_am    = r_act_im_am;
    assign od_im_fm    = r_act_im_fm;
    assign oc_fm_am    = r_act_ctrl[0];
    assign oc_dp_rst   = r_dp_rst;
    assign oc_state    = r_state;
    assign od_out_cnt  = r_out_cnt;

endmodule
